memory_block_master: RTL and testbench
======================================

Name: memory_block_master

Overview:
- Initiator end of the MemoryInterface protocol; drives the slave modport of the word RAM.
- On one command it transfers a block of BLOCK_SIZE consecutive words between an internal block buffer and memory, one word per handshake.
- Used by cache-fill and write-back logic; the client loads or unloads the buffer through a simple word-indexed port.

Parameters:
ADDRESS_WIDTH, 16, width of memoryInterface.address and baseAddress
DATA_WIDTH, 16, word width; must match the RAM
BLOCK_SIZE, 4, words per transfer; power of two, at least 2
TIMEOUT, 64, maximum cycles one word access may wait for functionComplete
INDEX_WIDTH, $clog2(BLOCK_SIZE), buffer index width

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
memoryInterface  MemoryInterface.master  -  address, dataOut, readEnabled, writeEnabled driven; dataIn, functionComplete sampled
request  input  1  start a transfer; sampled only in IDLE
write  input  1  1 = buffer to memory, 0 = memory to buffer; latched with request
baseAddress  input  ADDRESS_WIDTH  first word address; latched with request
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle pulse when a transfer ends (success or error)
error  output  1  set on timeout; held until the next accepted request
bufferIndex  input  INDEX_WIDTH  client buffer word select
bufferWriteData  input  DATA_WIDTH  client write data
bufferWriteEnable  input  1  client buffer write; ignored while busy
bufferReadData  output  DATA_WIDTH  combinational buffer[bufferIndex]

Behaviour:
- Reset (reset low, asynchronous): state IDLE. address, dataOut, wordIndex and timeout counter are 0. readEnabled, writeEnabled, busy, done and error are 0. Buffer contents are not reset.
- All memoryInterface outputs are registered. address and dataOut are stable for the whole time an enable is high.
- IDLE:
  - request=1 latches write and baseAddress.
  - wordIndex <= 0 and error <= 0.
  - Next state is ACCESS with address=baseAddress, dataOut=buffer[0] when write=1, and the matching enable high.
- ACCESS (enable high):
  - The timeout counter increments each cycle.
  - On functionComplete=1 for a read, buffer[wordIndex] <= dataIn at that edge.
  - The enable deasserts at that edge and the timeout counter clears.
  - If wordIndex = BLOCK_SIZE-1, the next state is IDLE with done=1 for one cycle. Otherwise the next state is GAP.
- GAP:
  - Exactly one cycle with both enables low, which lets the slave reload its delay counter.
  - Then wordIndex+1, address+1 (wraps modulo 2^ADDRESS_WIDTH), dataOut=buffer[wordIndex+1] on write, enable high, and the next state is ACCESS.
- Timeout: if the counter reaches TIMEOUT-1 in ACCESS without functionComplete (for example, an out-of-range address):
  - The enable drops and error <= 1.
  - The next state is IDLE with done=1.
  - Buffer words already transferred stay as they are.
- functionComplete is ignored outside ACCESS.
- readEnabled and writeEnabled are never both high.
- Latency: per word = slave DELAY cycles + 1 gap. For a successful block, done goes high BLOCK_SIZE*(DELAY+1) cycles after the request edge.
- A request while busy is ignored.
- Client buffer writes are ignored while busy. Client reads are always allowed; during a read transfer they return the partly updated contents.
- Reset asserted mid-transfer: enables drop immediately (asynchronously), no done pulse, state IDLE.

Decomposition:
- Package memory_master_pkg holds:
  - typedef enum state_t {IDLE, ACCESS, GAP}
  - a helper function for the default TIMEOUT width
- Sub-module block_buffer: BLOCK_SIZE x DATA_WIDTH register file.
  - Client port: write on bufferWriteEnable, combinational read.
  - Master port: write on read-complete, combinational read of wordIndex.
  - The ports are muxed by busy.

Test Plan (slave RAM with DELAY=4, SIZE_IN_WORDS=1024):
- RAM preloaded with 0x0100..0x0103 at addresses 0x10..0x13; request, write=0, base=0x10 -> done at request+20 cycles; buffer 0..3 = 0x0100..0x0103; error=0.
- Client writes 0xA000..0xA003 to buffer 0..3; request, write=1, base=0x20 -> done at +20; RAM[0x20..0x23] = 0xA000..0xA003; each enable high exactly 4 cycles with a 1-cycle low gap between words.
- Read at base=0x3FE with BLOCK_SIZE=4 -> words 0 and 1 complete; address 0x400 times out after 64 cycles -> done with error=1; buffer[0..1] updated.
- A second request and bufferWriteEnable during a busy transfer -> no effect on address sequence or buffer; next request clears error.
- reset driven low in the 2nd ACCESS cycle of word 2 -> readEnabled low in the same cycle; busy=done=error=0; a later request completes normally.
- Base 0xFFFE, read -> addresses issued are 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap-around); use a slave stub that always completes.

Source files
------------

// File: rtl/memory_master_pkg.sv
// Shared types and helpers for the block-transfer memory master.
package memory_master_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, GAP} state_t;

    // Counter width able to hold TIMEOUT-1; never narrower than one bit.
    function automatic int timeout_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/block_buffer.sv
// BLOCK_SIZE x DATA_WIDTH word buffer shared by the client and the transfer engine.
module block_buffer #(
    parameter int DATA_WIDTH  = 16,
    parameter int BLOCK_SIZE  = 4,
    parameter int INDEX_WIDTH = $clog2(BLOCK_SIZE)
) (
    input  logic                   clock,
    input  logic                   busy_i,
    input  logic [INDEX_WIDTH-1:0] client_idx_i,
    input  logic [DATA_WIDTH-1:0]  client_wdata_i,
    input  logic                   client_we_i,
    output logic [DATA_WIDTH-1:0]  client_rdata_o,
    input  logic [INDEX_WIDTH-1:0] master_widx_i,
    input  logic [DATA_WIDTH-1:0]  master_wdata_i,
    input  logic                   master_we_i,
    input  logic [INDEX_WIDTH-1:0] master_ridx_i,
    output logic [DATA_WIDTH-1:0]  master_rdata_o
);

    logic [DATA_WIDTH-1:0]  mem_q [BLOCK_SIZE];
    logic                   we;
    logic [INDEX_WIDTH-1:0] widx;
    logic [DATA_WIDTH-1:0]  wdata;

    // The transfer engine owns the write port for the whole time it is busy.
    always_comb begin
        we    = busy_i ? master_we_i    : client_we_i;
        widx  = busy_i ? master_widx_i  : client_idx_i;
        wdata = busy_i ? master_wdata_i : client_wdata_i;
    end

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    assign client_rdata_o = mem_q[client_idx_i];
    assign master_rdata_o = mem_q[master_ridx_i];

endmodule

// File: rtl/memory_block_master.sv
// Block-transfer initiator: moves BLOCK_SIZE consecutive words between the
// internal buffer and a handshaking word RAM, with a per-word timeout.
//
//   state  | meaning
//   IDLE   | waiting for request; done pulses here after a transfer
//   ACCESS | one enable high, waiting for functionComplete or timeout
//   GAP    | one cycle with both enables low before the next word
module memory_block_master
    import memory_master_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int BLOCK_SIZE    = 4,
    parameter int TIMEOUT       = 64,
    parameter int INDEX_WIDTH   = $clog2(BLOCK_SIZE)
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0]    dataOut,
    output logic                     readEnabled,
    output logic                     writeEnabled,
    input  logic [DATA_WIDTH-1:0]    dataIn,
    input  logic                     functionComplete,
    input  logic                     request,
    input  logic                     write,
    input  logic [ADDRESS_WIDTH-1:0] baseAddress,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    input  logic [INDEX_WIDTH-1:0]   bufferIndex,
    input  logic [DATA_WIDTH-1:0]    bufferWriteData,
    input  logic                     bufferWriteEnable,
    output logic [DATA_WIDTH-1:0]    bufferReadData
);

    localparam int TW = timeout_width(TIMEOUT);

    state_t                   state_q, state_d;
    logic                     write_q, write_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    dout_q, dout_d;
    logic                     rd_en_q, rd_en_d;
    logic                     wr_en_q, wr_en_d;
    logic [INDEX_WIDTH-1:0]   idx_q, idx_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic                     m_we;
    logic [INDEX_WIDTH-1:0]   m_ridx;
    logic [DATA_WIDTH-1:0]    m_rdata;

    assign busy = (state_q != IDLE);

    block_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_buffer (
        .clock         (clock),
        .busy_i        (busy),
        .client_idx_i  (bufferIndex),
        .client_wdata_i(bufferWriteData),
        .client_we_i   (bufferWriteEnable),
        .client_rdata_o(bufferReadData),
        .master_widx_i (idx_q),
        .master_wdata_i(dataIn),
        .master_we_i   (m_we),
        .master_ridx_i (m_ridx),
        .master_rdata_o(m_rdata)
    );

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rd_en_d = rd_en_q;
        wr_en_d = wr_en_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        err_d   = err_q;
        m_we    = 1'b0;
        m_ridx  = idx_q + INDEX_WIDTH'(1);
        case (state_q)
            IDLE: begin
                m_ridx = '0;
                if (request) begin
                    write_d = write;
                    addr_d  = baseAddress;
                    if (write) dout_d = m_rdata;
                    rd_en_d = ~write;
                    wr_en_d = write;
                    idx_d   = '0;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                tmo_d = tmo_q + TW'(1);
                if (functionComplete) begin
                    m_we    = ~write_q;
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                    tmo_d   = '0;
                    if (idx_q == INDEX_WIDTH'(BLOCK_SIZE - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                    tmo_d   = '0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            GAP: begin
                idx_d   = idx_q + INDEX_WIDTH'(1);
                addr_d  = addr_q + ADDRESS_WIDTH'(1);
                if (write_q) dout_d = m_rdata;
                rd_en_d = ~write_q;
                wr_en_d = write_q;
                state_d = ACCESS;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            idx_q   <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign address      = addr_q;
    assign dataOut      = dout_q;
    assign readEnabled  = rd_en_q;
    assign writeEnabled = wr_en_q;
    assign done         = done_q;
    assign error        = err_q;

endmodule

// File: tb/tb_memory_block_master.sv
// Bench for memory_block_master: word-RAM slave with configurable delay,
// window monitor on the enables, and a word-level model of buffer and RAM.
module tb_memory_block_master;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int BS = 4;
    localparam int TMO = 64;
    localparam int IW = 2;
    localparam int RAM_WORDS = 1024;
    localparam int MAXW = 512;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [AW-1:0] address;
    logic [DW-1:0] dataOut, dataIn;
    logic readEnabled, writeEnabled, functionComplete;
    logic request = 1'b0, write = 1'b0;
    logic [AW-1:0] baseAddress = '0;
    logic busy, done, error;
    logic [IW-1:0] bufferIndex = '0;
    logic [DW-1:0] bufferWriteData = '0;
    logic bufferWriteEnable = 1'b0;
    logic [DW-1:0] bufferReadData;

    always #5 clock = ~clock;

    memory_block_master #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS), .TIMEOUT(TMO), .INDEX_WIDTH(IW)
    ) dut (
        .clock(clock), .reset(reset),
        .address(address), .dataOut(dataOut), .readEnabled(readEnabled), .writeEnabled(writeEnabled),
        .dataIn(dataIn), .functionComplete(functionComplete),
        .request(request), .write(write), .baseAddress(baseAddress),
        .busy(busy), .done(done), .error(error),
        .bufferIndex(bufferIndex), .bufferWriteData(bufferWriteData),
        .bufferWriteEnable(bufferWriteEnable), .bufferReadData(bufferReadData)
    );

    // Slave RAM: completes DELAY cycles after an enable rises; out-of-range
    // addresses never complete unless stub_mode is set.
    logic [DW-1:0] ram [RAM_WORDS];
    logic tb_ram_we = 1'b0;
    logic [9:0] tb_ram_addr = '0;
    logic [DW-1:0] tb_ram_data = '0;
    int slv_delay = 4;
    bit stub_mode = 1'b0;
    int slv_cnt;
    logic en, in_range;

    assign en = readEnabled | writeEnabled;
    assign in_range = (address < AW'(RAM_WORDS));
    assign functionComplete = en && (in_range || stub_mode) && (slv_cnt == slv_delay - 1);
    assign dataIn = stub_mode ? (address ^ 16'h5A5A) : ram[address[9:0]];

    always @(posedge clock or negedge reset) begin
        if (!reset) slv_cnt <= 0;
        else if (en && !functionComplete) slv_cnt <= slv_cnt + 1;
        else slv_cnt <= 0;
    end

    always @(posedge clock) begin
        if (tb_ram_we) ram[tb_ram_addr] <= tb_ram_data;
        else if (writeEnabled && functionComplete && in_range && !stub_mode) ram[address[9:0]] <= dataOut;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Enable-window monitor
    logic [AW-1:0] win_addr [MAXW];
    logic [DW-1:0] win_data [MAXW];
    bit win_wr [MAXW];
    int win_start [MAXW];
    int win_len [MAXW];
    int win_cnt = 0;
    bit prev_en = 1'b0;
    int both_bad = 0;
    int hold_bad = 0;

    always @(negedge clock) begin
        prev_en <= en;
        if (readEnabled && writeEnabled) both_bad <= both_bad + 1;
        if (en && win_cnt < MAXW) begin
            if (!prev_en) begin
                win_addr[win_cnt]  <= address;
                win_data[win_cnt]  <= dataOut;
                win_wr[win_cnt]    <= writeEnabled;
                win_start[win_cnt] <= cyc;
                win_len[win_cnt]   <= 1;
                win_cnt            <= win_cnt + 1;
            end else begin
                win_len[win_cnt-1] <= win_len[win_cnt-1] + 1;
                if (address != win_addr[win_cnt-1] || dataOut != win_data[win_cnt-1])
                    hold_bad <= hold_bad + 1;
            end
        end
    end

    // Reference model at word level
    logic [DW-1:0] ram_model [RAM_WORDS];
    logic [DW-1:0] buf_model [BS];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic client_write(input int i, input logic [DW-1:0] v);
        @(negedge clock);
        bufferIndex = IW'(i);
        bufferWriteData = v;
        bufferWriteEnable = 1'b1;
        @(negedge clock);
        bufferWriteEnable = 1'b0;
        buf_model[i] = v;
    endtask

    task automatic check_buffer(input string tag);
        for (int i = 0; i < BS; i++) begin
            @(negedge clock);
            bufferIndex = IW'(i);
            #1;
            check_val($sformatf("%s_buf%0d", tag, i), 32'(bufferReadData), 32'(buf_model[i]));
        end
    endtask

    task automatic do_xfer(input string tag, input bit wr, input logic [AW-1:0] base,
                           input int nok, input bit exp_err, input bit disturb);
        int w0, hb0, bb0, r, d, nwin, exp_nwin, exp_lat;
        bit seen;
        logic [AW-1:0] ea;
        w0 = win_cnt;
        hb0 = hold_bad;
        bb0 = both_bad;
        @(negedge clock);
        request = 1'b1;
        write = wr;
        baseAddress = base;
        @(negedge clock);
        request = 1'b0;
        r = cyc;
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        check_val({tag, "_err_clr"}, 32'(error), 32'd0);
        if (disturb) begin
            @(negedge clock);
            request = 1'b1;
            write = ~wr;
            baseAddress = base + 16'h0100;
            bufferIndex = '0;
            bufferWriteData = 16'hFFFF;
            bufferWriteEnable = 1'b1;
            @(negedge clock);
            request = 1'b0;
            bufferWriteEnable = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            if (done) seen = 1'b1;
            else @(negedge clock);
        end
        check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        d = cyc;
        // done is sampled by the client on the edge after it rises
        exp_lat = exp_err ? nok * (slv_delay + 1) + TMO + 1 : BS * (slv_delay + 1);
        check_val({tag, "_latency"}, 32'(d + 1 - r), 32'(exp_lat));
        check_val({tag, "_error"}, 32'(error), 32'(exp_err));
        @(negedge clock);
        check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_val({tag, "_idle"}, 32'(busy), 32'd0);

        nwin = win_cnt - w0;
        exp_nwin = exp_err ? nok + 1 : BS;
        check_val({tag, "_windows"}, 32'(nwin), 32'(exp_nwin));
        for (int i = 0; i < nwin && i < exp_nwin; i++) begin
            ea = base + AW'(i);
            check_val($sformatf("%s_addr%0d", tag, i), 32'(win_addr[w0+i]), 32'(ea));
            check_val($sformatf("%s_len%0d", tag, i), 32'(win_len[w0+i]), 32'(i < nok ? slv_delay : TMO));
            check_val($sformatf("%s_dir%0d", tag, i), 32'(win_wr[w0+i]), 32'(wr));
            if (wr) check_val($sformatf("%s_wdata%0d", tag, i), 32'(win_data[w0+i]), 32'(buf_model[i]));
            if (i > 0)
                check_val($sformatf("%s_gap%0d", tag, i),
                          32'(win_start[w0+i] - win_start[w0+i-1] - win_len[w0+i-1]), 32'd1);
        end
        check_val({tag, "_hold"}, 32'(hold_bad - hb0), 32'd0);
        check_val({tag, "_excl"}, 32'(both_bad - bb0), 32'd0);

        for (int i = 0; i < nok; i++) begin
            ea = base + AW'(i);
            if (!wr) buf_model[i] = stub_mode ? (ea ^ 16'h5A5A) : ram_model[ea[9:0]];
            else if (!stub_mode) ram_model[ea[9:0]] = buf_model[i];
        end
        check_buffer(tag);
        if (wr && !stub_mode) begin
            for (int i = 0; i < BS; i++) begin
                ea = base + AW'(i);
                if (ea < AW'(RAM_WORDS))
                    check_val($sformatf("%s_ram%0d", tag, i), 32'(ram[ea[9:0]]), 32'(ram_model[ea[9:0]]));
            end
        end
    endtask

    initial begin
        logic [DW-1:0] v;
        logic [AW-1:0] base;
        int r;
        bit wr;

        repeat (3) @(negedge clock);
        check_val("rst_address", 32'(address), 32'd0);
        check_val("rst_dataOut", 32'(dataOut), 32'd0);
        check_val("rst_rd_en", 32'(readEnabled), 32'd0);
        check_val("rst_wr_en", 32'(writeEnabled), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_error", 32'(error), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < RAM_WORDS; i++) begin
            v = (i >= 16'h10 && i <= 16'h13) ? DW'(16'h0100 + i - 16'h10) : DW'($urandom);
            @(negedge clock);
            tb_ram_we = 1'b1;
            tb_ram_addr = 10'(i);
            tb_ram_data = v;
            ram_model[i] = v;
        end
        @(negedge clock);
        tb_ram_we = 1'b0;

        do_xfer("rd_basic", 1'b0, 16'h0010, BS, 1'b0, 1'b0);

        for (int i = 0; i < BS; i++) client_write(i, DW'(16'hA000 + i));
        do_xfer("wr_basic", 1'b1, 16'h0020, BS, 1'b0, 1'b0);

        do_xfer("rd_timeout", 1'b0, 16'h03FE, 2, 1'b1, 1'b0);
        repeat (2) @(negedge clock);
        check_val("timeout_err_hold", 32'(error), 32'd1);

        do_xfer("busy_ignore", 1'b1, 16'h0080, BS, 1'b0, 1'b1);

        base = 16'h0040;
        @(negedge clock);
        request = 1'b1;
        write = 1'b0;
        baseAddress = base;
        @(negedge clock);
        request = 1'b0;
        r = cyc;
        while (cyc < r + 11) @(negedge clock);
        check_val("mid_rd_en", 32'(readEnabled), 32'd1);
        check_val("mid_addr", 32'(address), 32'(base + 16'd2));
        reset = 1'b0;
        #1;
        check_val("arst_rd_en", 32'(readEnabled), 32'd0);
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_done", 32'(done), 32'd0);
        check_val("arst_error", 32'(error), 32'd0);
        check_val("arst_addr", 32'(address), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < BS; i++) begin
            @(negedge clock);
            check_val($sformatf("arst_nodone%0d", i), 32'(done), 32'd0);
        end
        for (int i = 0; i < 2; i++) buf_model[i] = ram_model[base[9:0] + 10'(i)];
        do_xfer("after_rst", 1'b0, base, BS, 1'b0, 1'b0);

        stub_mode = 1'b1;
        do_xfer("wrap", 1'b0, 16'hFFFE, BS, 1'b0, 1'b0);
        stub_mode = 1'b0;

        for (int t = 0; t < 8; t++) begin
            slv_delay = $urandom_range(1, 6);
            wr = 1'($urandom_range(0, 1));
            base = AW'($urandom_range(0, RAM_WORDS - BS));
            if (wr) for (int i = 0; i < BS; i++) client_write(i, DW'($urandom));
            do_xfer($sformatf("rand%0d", t), wr, base, BS, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
